// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: streams a block of operand-buffer rows into the skew stage
// ahead of the systolic array. One read per cycle while feeding, then waits
// for the skew pipeline to drain before pulsing done.

`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif
`ifndef SINGLE
`define SINGLE 32
`endif

module skew_feed_ctrl #(
  parameter int SYS_ARRAY_LEN = `SYS_ARRAY_LEN,
  parameter int ADDR_W        = 10,
  parameter int LEN_W         = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [LEN_W-1:0]                  num_rows,
  input  logic                              hold,
  output logic                              ready,
  output logic                              busy,
  output logic                              done,
  output logic                              rd_en,
  output logic [ADDR_W-1:0]                 rd_addr,
  input  logic [`SINGLE*SYS_ARRAY_LEN-1:0]  rd_data,
  output logic [`SINGLE*SYS_ARRAY_LEN-1:0]  data_out,
  output logic                              data_valid
);

  // Drain covers one cycle of buffer read latency plus the deepest skew lane.
  localparam int DRAIN_W = $clog2(SYS_ARRAY_LEN + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(SYS_ARRAY_LEN + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_cnt, addr_nxt;
  logic [LEN_W-1:0]    rem_cnt, rem_nxt;
  logic [DRAIN_W-1:0]  drain_cnt, drain_nxt;
  // A zero-length job spends one quiet cycle in DONE before the pulse, so its
  // start-to-done latency is two cycles.
  logic                zero_wait, zero_wait_nxt;

  assign rd_addr  = addr_cnt;
  assign data_out = rd_data;

  // Next-state, counter updates and control outputs.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_cnt;
    rem_nxt       = rem_cnt;
    drain_nxt     = drain_cnt;
    zero_wait_nxt = zero_wait;
    ready         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    rd_en         = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          addr_nxt = base_addr;
          rem_nxt  = num_rows;
          if (num_rows == '0) begin
            state_nxt     = DONE;
            zero_wait_nxt = 1'b1;
          end else begin
            state_nxt = FEED;
          end
        end
      end
      FEED: begin
        busy = 1'b1;
        if (!hold) begin
          rd_en    = 1'b1;
          addr_nxt = addr_cnt + ADDR_W'(1);
          rem_nxt  = rem_cnt - LEN_W'(1);
          if (rem_cnt == LEN_W'(1)) begin
            state_nxt = DRAIN;
            drain_nxt = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt <= DRAIN_W'(1)) begin
          state_nxt = DONE;
          drain_nxt = '0;
        end else begin
          drain_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      DONE: begin
        if (zero_wait) begin
          zero_wait_nxt = 1'b0;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and the valid flag that trails each read by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      rem_cnt    <= '0;
      drain_cnt  <= '0;
      zero_wait  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_cnt   <= addr_nxt;
      rem_cnt    <= rem_nxt;
      drain_cnt  <= drain_nxt;
      zero_wait  <= zero_wait_nxt;
      data_valid <= rd_en;
    end
  end

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Testbench for skew_feed_ctrl: table of jobs with a per-cycle timing model,
// plus a read/data scoreboard fed at job launch and drained by a monitor.

`ifndef SINGLE
`define SINGLE 32
`endif

module tb_skew_feed_ctrl;

  localparam int L  = 4;
  localparam int AW = 10;
  localparam int LW = 10;
  localparam int DW = L * `SINGLE;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_rows = '0;
  logic          ready, busy, done, rd_en, data_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] data_out;

  int total = 0;
  int bad = 0;
  bit mon_on = 1'b0;

  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            hold_after;
    int            hold_len;
    bit            intrude;
    bit            hold_drain;
    int            lat;
  } vec_t;

  vec_t vecs[8];

  skew_feed_ctrl #(.SYS_ARRAY_LEN(L), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .hold(hold), .ready(ready), .busy(busy),
    .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .data_out(data_out), .data_valid(data_valid)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Buffer contents: every lane tagged with its lane number and row address.
  function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++)
      r[i*`SINGLE +: `SINGLE] = `SINGLE'({8'(i), 8'h5A, 6'd0, a});
    return r;
  endfunction

  // Operand buffer with one cycle of read latency.
  always @(posedge clk) rd_data <= rd_en ? row_of(rd_addr) : '0;

  task automatic check_output(input string what, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", what, act, exp);
    end
  endtask

  // Scoreboard drain: every read and every valid row must match the queue.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (rd_en) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL spurious_read: got rd_addr=%0h want no read", rd_addr);
        end else begin
          check_output("rd_addr", DW'(rd_addr), DW'(addr_q.pop_front()));
        end
      end
      if (data_valid) begin
        if (data_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL spurious_valid: got data_valid=1 want 0");
        end else begin
          check_output("data_out", data_out, data_q.pop_front());
        end
      end
    end
  end

  // Runs one job and checks {ready,busy,done,rd_en,data_valid} every cycle.
  task automatic apply_stimulus(input int idx, input vec_t v);
    int   issued = 0;
    int   hold_cnt = 0;
    logic prev_rd = 1'b0;
    logic hold_k, exp_rd;
    logic [4:0] exp_ctl;
    for (int i = 0; i < v.n; i++) begin
      addr_q.push_back(v.base + AW'(i));
      data_q.push_back(row_of(v.base + AW'(i)));
    end
    @(negedge clk);
    start = 1'b1; base_addr = v.base; num_rows = LW'(v.n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= v.lat + 1; k++) begin
      hold_k = 1'b0;
      if (k <= v.lat) begin
        if (issued < v.n && issued == v.hold_after && hold_cnt < v.hold_len) hold_k = 1'b1;
        if (v.hold_drain && v.n > 0 && issued >= v.n) hold_k = 1'b1;
      end
      hold = hold_k;
      if (v.intrude && (k == 2 || k == v.n + 2 || k == v.lat)) begin
        start = 1'b1; base_addr = AW'(10'h155); num_rows = LW'(7);
      end else begin
        start = 1'b0;
      end
      exp_rd = (issued < v.n) && !hold_k;
      if (k <= v.lat)
        exp_ctl = {1'b0, (v.n > 0 && k < v.lat), (k == v.lat), exp_rd, prev_rd};
      else
        exp_ctl = {1'b1, 1'b0, 1'b0, 1'b0, prev_rd};
      @(negedge clk);
      check_output($sformatf("job%0d ctl k=%0d", idx, k),
                   DW'({ready, busy, done, rd_en, data_valid}), DW'(exp_ctl));
      if (hold_k && issued < v.n) hold_cnt++;
      if (exp_rd) issued++;
      prev_rd = exp_rd;
      @(posedge clk); #1;
    end
    hold = 1'b0; start = 1'b0;
    check_output($sformatf("job%0d reads left", idx), DW'(addr_q.size()), DW'(0));
    check_output($sformatf("job%0d rows left", idx), DW'(data_q.size()), DW'(0));
  endtask

  // Reset after two of five reads, then a normal job from 0x20.
  task automatic reset_mid_feed();
    vec_t v;
    for (int i = 0; i < 5; i++) begin
      addr_q.push_back(AW'(10'h040 + i));
      data_q.push_back(row_of(AW'(10'h040 + i)));
    end
    @(negedge clk);
    start = 1'b1; base_addr = AW'(10'h040); num_rows = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_output("reset mid-feed ctl", DW'({ready, busy, done, rd_en, data_valid}), DW'(5'b10000));
    check_output("reset mid-feed rd_addr", DW'(rd_addr), DW'(0));
    addr_q.delete();
    data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output($sformatf("post-reset idle %0d", k),
                   DW'({ready, busy, done, rd_en, data_valid}), DW'(5'b10000));
    end
    v = '{AW'(10'h020), 3, -1, 0, 1'b0, 1'b0, 9};
    apply_stimulus(8, v);
  endtask

  // Main sequence.
  initial begin
    vecs[0] = '{AW'(10'h010),    3, -1, 0, 1'b0, 1'b0, 9};
    vecs[1] = '{AW'(10'h030),    4,  2, 2, 1'b0, 1'b0, 12};
    vecs[2] = '{AW'(10'h000),    0, -1, 0, 1'b0, 1'b0, 2};
    vecs[3] = '{AW'(10'h3FE),    4, -1, 0, 1'b0, 1'b0, 10};
    vecs[4] = '{AW'(10'h100),    6, -1, 0, 1'b1, 1'b1, 12};
    vecs[5] = '{AW'(10'h200),    1,  0, 3, 1'b0, 1'b0, 10};
    vecs[6] = '{AW'(10'h3FF),    2,  1, 1, 1'b0, 1'b0, 9};
    vecs[7] = '{AW'(10'h000), 1023, -1, 0, 1'b0, 1'b0, 1029};

    #1 rst = 1'b1;
    #2;
    check_output("reset ctl", DW'({ready, busy, done, rd_en, data_valid}), DW'(5'b10000));
    check_output("reset rd_addr", DW'(rd_addr), DW'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;

    for (int i = 0; i < 8; i++) apply_stimulus(i, vecs[i]);
    reset_mid_feed();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no end of test want finish before limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
